// File: rtl/ram_stream_reader_if.sv
// Read-port and stream bundle for ram_stream_reader.
// master = the reader engine; slave = the RAM read port plus downstream consumer.
`timescale 1ns/1ps

interface ram_stream_reader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (
    output ram_rd_en, ram_rd_addr, m_valid, m_data, m_last,
    input  ram_rd_data, m_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, m_valid, m_data, m_last,
    output ram_rd_data, m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams LEN words from a 1-cycle-latency SDP RAM read port, starting at BASE_ADDR
// with modulo-DEPTH wrap, through a 3-entry credit-controlled valid/ready buffer.
`timescale 1ns/1ps

module ram_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [DEPTH_LOG-1:0] i_base_addr,
  input  logic [DEPTH_LOG:0]   i_len,
  output logic                 o_busy,
  output logic                 o_done,
  ram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam int                   BUF_DEPTH = 3;
  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0]   LEN_ZERO  = '0;
  localparam logic [DEPTH_LOG:0]   LEN_ONE   = (DEPTH_LOG + 1)'(1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_en;
  logic                 r_rd_last;
  logic [DEPTH_LOG-1:0] r_rd_addr;
  logic [DEPTH_LOG:0]   r_len;
  logic [DEPTH_LOG:0]   r_issued;
  logic                 r_inflight;
  logic                 r_inflight_last;
  logic [WIDTH-1:0]     r_buf_data [BUF_DEPTH];
  logic                 r_buf_last [BUF_DEPTH];
  logic [1:0]           r_count;

  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_count_next;
  logic [1:0]           w_wr_idx;
  logic                 w_credit_ok;
  logic                 w_last_hs;
  logic [DEPTH_LOG-1:0] w_next_addr;
  logic [DEPTH_LOG:0]   w_issued_next;

  // Data returned by the RAM this cycle belongs to the read issued last cycle.
  assign w_push        = r_inflight;
  assign w_pop         = (r_count != 2'd0) && bus.m_ready;
  assign w_count_next  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_wr_idx      = r_count - {1'b0, w_pop};
  assign w_last_hs     = w_pop && r_buf_last[0];
  assign w_next_addr   = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
  assign w_issued_next = r_issued + 1'b1;

  // After the next edge the buffer holds w_count_next words and r_rd_en becomes the
  // in-flight read; one more read may only be issued if that still leaves room.
  assign w_credit_ok   = ({1'b0, w_count_next} + {2'b00, r_rd_en}) < 3'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_rd_en         <= 1'b0;
      r_rd_last       <= 1'b0;
      r_rd_addr       <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_count         <= '0;
      // NOTE: the buffer is only three flops deep and its head drives M_DATA/M_LAST,
      // which must read 0 in reset, so it is reset like ordinary state.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; a default written
      // first and overridden later in the same block is legal because the last
      // scheduled update wins.
      r_done          <= 1'b0;
      r_inflight      <= r_rd_en;
      r_inflight_last <= r_rd_last;
      r_count         <= w_count_next;

      if (w_pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          r_buf_data[i] <= r_buf_data[i+1];
          r_buf_last[i] <= r_buf_last[i+1];
        end
      end
      if (w_push) begin
        r_buf_data[w_wr_idx] <= bus.ram_rd_data;
        r_buf_last[w_wr_idx] <= r_inflight_last;
      end

      case (r_state)
        ST_IDLE: begin
          r_rd_en   <= 1'b0;
          r_rd_last <= 1'b0;
          if (i_start && !r_done) begin
            if (i_len == LEN_ZERO) begin
              r_done <= 1'b1;
            end else begin
              r_state   <= ST_RUN;
              r_busy    <= 1'b1;
              r_len     <= i_len;
              r_rd_en   <= 1'b1;
              r_rd_addr <= i_base_addr;
              r_issued  <= LEN_ONE;
              r_rd_last <= (i_len == LEN_ONE);
            end
          end
        end

        ST_RUN: begin
          if (r_issued == r_len) begin
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_state   <= ST_FLUSH;
          end else if (w_credit_ok) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_next_addr;
            r_issued  <= w_issued_next;
            r_rd_last <= (w_issued_next == r_len);
          end else begin
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
          end
        end

        ST_FLUSH: begin
          if (w_last_hs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_rd_en   = r_rd_en;
  assign bus.ram_rd_addr = r_rd_addr;
  assign bus.m_valid     = (r_count != 2'd0);
  assign bus.m_data      = r_buf_data[0];
  assign bus.m_last      = r_buf_last[0];
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model holding 0x100+addr, queue scoreboard fed by
// the command driver and drained by a negedge monitor, plus a DEPTH=24 instance.
`timescale 1ns/1ps

module tb_ram_stream_reader;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 32;
  localparam int AW      = $clog2(DEPTH);
  localparam int DEPTH24 = 24;
  localparam int AW24    = $clog2(DEPTH24);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            i_start = 1'b0;
  logic [AW-1:0]   i_base  = '0;
  logic [AW:0]     i_len   = '0;
  logic            o_busy, o_done;
  logic            start24 = 1'b0;
  logic [AW24-1:0] base24  = '0;
  logic [AW24:0]   len24   = '0;
  logic            busy24, done24;

  ram_stream_reader_if #(.WIDTH(WIDTH), .AW(AW))   bus ();
  ram_stream_reader_if #(.WIDTH(WIDTH), .AW(AW24)) bus24 ();

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .bus(bus.master)
  );

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH24)) dut24 (
    .clk(clk), .rst_n(rst_n), .i_start(start24), .i_base_addr(base24), .i_len(len24),
    .o_busy(busy24), .o_done(done24), .bus(bus24.master)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ram_word(input int addr);
    return WIDTH'(32'h100 + addr);
  endfunction

  // Behavioural SDP RAM read ports: registered data one cycle after the enable.
  always @(posedge clk) begin
    if (bus.ram_rd_en)   bus.ram_rd_data   <= ram_word(int'(bus.ram_rd_addr));
    if (bus24.ram_rd_en) bus24.ram_rd_data <= ram_word(int'(bus24.ram_rd_addr));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  beat_t exp24_q[$];
  int    addr_log[$];
  int    addr24_log[$];
  int    reads = 0, beats = 0, done_cnt = 0, done24_cnt = 0;
  int    last_hs_cyc = -1;
  int    rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, otherwise random.
  initial begin
    int phase = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.m_ready = 1'b1;
        1: begin
          bus.m_ready = (phase == 0) || (phase == 3);
          phase = (phase + 1) % 4;
        end
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, read credit, done counting.
  initial begin
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;
    beat_t            e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp24_q.delete();
        prev_stall = 1'b0;
        beats = reads;
      end else begin
        if (bus.ram_rd_en) begin
          reads++;
          addr_log.push_back(int'(bus.ram_rd_addr));
        end
        if (o_busy) check("credit_le_3", 64'(reads - beats <= 3), 1);
        if (prev_stall)
          check("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, prev_last, prev_data});
        if (bus.m_valid && bus.m_ready) begin
          beats++;
          check("beat_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_data", bus.m_data, e.data);
            check("m_last", bus.m_last, e.last);
          end
          if (bus.m_last) last_hs_cyc = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        if (o_done) done_cnt++;

        if (bus24.ram_rd_en) addr24_log.push_back(int'(bus24.ram_rd_addr));
        if (bus24.m_valid && bus24.m_ready) begin
          check("d24_beat_expected", 64'(exp24_q.size() != 0), 1);
          if (exp24_q.size() != 0) begin
            e = exp24_q.pop_front();
            check("d24_m_data", bus24.m_data, e.data);
            check("d24_m_last", bus24.m_last, e.last);
          end
        end
        if (done24) done24_cnt++;
      end
    end
  end

  task automatic push_expected(input int base, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = ram_word((base + k) % DEPTH);
      b.last = (k == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_cmd(input int base, input int len, input int mode, input bit poke);
    int a0, b0, d0, t0, fv, tdone, max_cyc;
    bit got, busy_seen;
    rdy_mode = mode;
    @(posedge clk);
    #1;
    a0 = addr_log.size();
    b0 = beats;
    d0 = done_cnt;
    i_start = 1'b1;
    i_base  = AW'(base);
    i_len   = (AW + 1)'(len);
    push_expected(base, len);
    @(posedge clk);
    #1;
    t0 = cyc;
    i_start = 1'b0;
    if (poke) begin
      fork
        begin
          repeat (3) @(posedge clk);
          #1;
          i_start = 1'b1;
          i_base  = AW'(7);
          i_len   = (AW + 1)'(3);
          @(posedge clk);
          #1;
          i_start = 1'b0;
        end
      join_none
    end
    got = 0; busy_seen = 0; fv = -1; tdone = -1;
    max_cyc = 20 * len + 40;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.m_valid && fv < 0) fv = cyc;
      if (o_busy) busy_seen = 1;
      if (o_done) begin
        got = 1;
        tdone = cyc;
        check("busy_low_at_done", o_busy, 0);
        break;
      end
    end
    check("done_seen", got, 1);
    if (len == 0) begin
      check("zero_len_done_cycle", tdone, t0);
      check("zero_len_busy", busy_seen, 0);
    end else begin
      check("first_valid_latency", fv - t0, 2);
      check("done_after_last_beat", tdone, last_hs_cyc + 1);
      check("busy_seen", busy_seen, 1);
      if (mode == 0) check("throughput", last_hs_cyc - fv, len - 1);
    end
    repeat (4) @(negedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("beat_count", beats - b0, len);
    check("scoreboard_empty", exp_q.size(), 0);
    check("read_count", addr_log.size() - a0, len);
    for (int k = 0; k < len; k++)
      if (a0 + k < addr_log.size()) check("rd_addr", addr_log[a0 + k], (base + k) % DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    bit reached;
    beat_t b;
    bus24.m_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {o_busy, o_done, bus.ram_rd_en, bus.ram_rd_addr, bus.m_valid, bus.m_last, bus.m_data}, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    do_cmd(4, 5, 0, 0);
    do_cmd(30, 4, 0, 0);
    do_cmd(0, 8, 1, 0);
    do_cmd(10, 0, 0, 0);
    do_cmd(12, 6, 0, 1);
    do_cmd(31, 33, 1, 0);
    for (int n = 0; n < 6; n++)
      do_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)), 2, 0);

    // Reset mid-run after the third beat of a 10-word command.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    b0 = beats;
    d0 = done_cnt;
    i_start = 1'b1;
    i_base  = '0;
    i_len   = (AW + 1)'(10);
    push_expected(0, 10);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    reached = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (beats - b0 >= 3) begin
        reached = 1;
        break;
      end
    end
    check("reset_wait_third_beat", reached, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {o_busy, o_done, bus.ram_rd_en, bus.ram_rd_addr, bus.m_valid, bus.m_last, bus.m_data}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);
    do_cmd(0, 2, 0, 0);

    // Non-power-of-two depth wrap on the second instance.
    @(posedge clk);
    #1;
    d0 = done24_cnt;
    start24 = 1'b1;
    base24  = AW24'(22);
    len24   = (AW24 + 1)'(4);
    for (int k = 0; k < 4; k++) begin
      b.data = ram_word((22 + k) % DEPTH24);
      b.last = (k == 3);
      exp24_q.push_back(b);
    end
    @(posedge clk);
    #1;
    start24 = 1'b0;
    reached = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done24) begin
        reached = 1;
        break;
      end
    end
    check("d24_done_seen", reached, 1);
    repeat (3) @(negedge clk);
    #1;
    check("d24_done_once", done24_cnt - d0, 1);
    check("d24_scoreboard_empty", exp24_q.size(), 0);
    check("d24_read_count", addr24_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < addr24_log.size()) check("d24_rd_addr", addr24_log[k], (22 + k) % DEPTH24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
